// File: rtl/acc_core_if.sv
// rtl/acc_core_if.sv - request/acknowledge memory port shared by the accumulator core and its memory
interface acc_core_if #(
    parameter int DW = 16,
    parameter int AW = 13
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/acc_core.sv
// rtl/acc_core.sv - multicycle accumulator core with fetch/execute control and a single memory port
module acc_core #(
    parameter int            DW       = 16,
    parameter int            AW       = 13,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    acc_core_if.master    mem,
    output logic          halted,
    output logic          carry,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] acc_out
);
    typedef enum logic [2:0] {StFetch, StDecode, StRead, StExec, StStore, StHalt} stateT;
    typedef enum logic [2:0] {OpAdd, OpAnd, OpLda, OpSta, OpJmp, OpJz, OpSub, OpHalt} opcodeT;

    stateT         state;
    stateT         nextState;
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [DW-1:0] acc;
    logic [DW-1:0] mdr;
    opcodeT        opcode;
    logic [AW-1:0] operand;
    logic [DW:0]   aluSum;
    logic [DW:0]   aluDiff;
    logic          memReq;
    logic          memWe;
    logic [AW-1:0] memAddr;

    assign opcode  = opcodeT'(ir[DW-1:DW-3]);
    assign operand = ir[AW-1:0];
    // The extra top bit of the difference is the borrow out of the unsigned subtraction.
    assign aluSum  = {1'b0, acc} + {1'b0, mdr};
    assign aluDiff = {1'b0, acc} - {1'b0, mdr};

    if (DW > AW + 3) begin : gIgnoredIrBits
        logic unusedIrBits;
        assign unusedIrBits = ^ir[DW-4:AW];
    end

    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = operand;
        case (state)
            StFetch: begin
                memReq  = 1'b1;
                memAddr = pc;
                if (mem.mem_ack) nextState = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpAdd, OpAnd, OpLda, OpSub: nextState = StRead;
                    OpSta:                      nextState = StStore;
                    OpHalt:                     nextState = StHalt;
                    default:                    nextState = StFetch;
                endcase
            end
            StRead: begin
                memReq = 1'b1;
                if (mem.mem_ack) nextState = StExec;
            end
            StExec: nextState = StFetch;
            StStore: begin
                memReq = 1'b1;
                memWe  = 1'b1;
                if (mem.mem_ack) nextState = StFetch;
            end
            StHalt:  nextState = StHalt;
            default: nextState = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StFetch;
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            mdr   <= '0;
            carry <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                StFetch: begin
                    if (mem.mem_ack) begin
                        ir <= mem.mem_rdata;
                        pc <= pc + AW'(1);
                    end
                end
                StDecode: begin
                    if (opcode == OpJmp || (opcode == OpJz && acc == '0)) pc <= operand;
                end
                StRead: begin
                    if (mem.mem_ack) mdr <= mem.mem_rdata;
                end
                StExec: begin
                    case (opcode)
                        OpAdd: begin
                            acc   <= aluSum[DW-1:0];
                            carry <= aluSum[DW];
                        end
                        OpSub: begin
                            acc   <= aluDiff[DW-1:0];
                            carry <= aluDiff[DW];
                        end
                        OpAnd:   acc <= acc & mdr;
                        OpLda:   acc <= mdr;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Requests are withdrawn the instant reset asserts so an outstanding access is abandoned.
    assign mem.mem_req   = memReq & rst;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = acc;
    assign halted        = (state == StHalt);
    assign pc_out        = pc;
    assign acc_out       = acc;
endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - directed bench for acc_core checked against an instruction-level model
module tb_acc_core;
    localparam logic [2:0] OP_ADD = 3'd0, OP_AND = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4, OP_JZ = 3'd5, OP_SUB = 3'd6, OP_HALT = 3'd7;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        fetch;
        logic [31:0] acc;
        logic        carry;
    } accessT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, rst32;
    logic        sel;
    logic        ackR;
    int          checks = 0;
    int          errors = 0;
    int          mode;
    logic        spurious;
    int          holdAddr;
    int          remaining;
    logic        pending;
    logic        cmpEn;

    acc_core_if #(.DW(16), .AW(13)) bus16 ();
    acc_core_if #(.DW(32), .AW(20)) bus32 ();

    logic        halted16, carry16, halted32, carry32;
    logic [12:0] pc16;
    logic [15:0] acc16;
    logic [19:0] pc32;
    logic [31:0] acc32;

    acc_core #(.DW(16), .AW(13), .RESET_PC(13'h0)) dut16 (
        .clk(clk), .rst(rst16), .mem(bus16), .halted(halted16),
        .carry(carry16), .pc_out(pc16), .acc_out(acc16)
    );
    acc_core #(.DW(32), .AW(20), .RESET_PC(20'h100)) dut32 (
        .clk(clk), .rst(rst32), .mem(bus32), .halted(halted32),
        .carry(carry32), .pc_out(pc32), .acc_out(acc32)
    );

    logic [15:0] mem16 [0:8191];
    logic [31:0] mem32 [0:8191];
    logic [31:0] modelMem [0:8191];

    assign bus16.mem_rdata = mem16[bus16.mem_addr];
    assign bus32.mem_rdata = mem32[bus32.mem_addr[12:0]];
    assign bus16.mem_ack   = sel ? 1'b0 : ackR;
    assign bus32.mem_ack   = sel ? ackR : 1'b0;

    logic        cReq, cWe, cAck, cHalted, cCarry;
    logic [31:0] cAddr, cWdata, cPc, cAcc;
    always_comb begin
        if (sel) begin
            cReq = bus32.mem_req; cWe = bus32.mem_we; cAck = bus32.mem_ack;
            cAddr = 32'(bus32.mem_addr); cWdata = bus32.mem_wdata;
            cHalted = halted32; cCarry = carry32; cPc = 32'(pc32); cAcc = acc32;
        end else begin
            cReq = bus16.mem_req; cWe = bus16.mem_we; cAck = bus16.mem_ack;
            cAddr = 32'(bus16.mem_addr); cWdata = 32'(bus16.mem_wdata);
            cHalted = halted16; cCarry = carry16; cPc = 32'(pc16); cAcc = 32'(acc16);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: decides ack for the coming edge and commits stores.
    always begin
        @(negedge clk);
        if (!cReq) begin
            pending = 1'b0;
            ackR = (mode == 0) ? 1'b1 : (spurious ? 1'($urandom_range(0, 1)) : 1'b0);
        end else if (mode == 2 && cAddr == holdAddr) begin
            ackR = 1'b0;
        end else if (mode == 1) begin
            if (!pending) begin
                pending   = 1'b1;
                remaining = $urandom_range(0, 5);
            end
            if (remaining == 0) begin
                ackR    = 1'b1;
                pending = 1'b0;
            end else begin
                ackR = 1'b0;
                remaining--;
            end
        end else begin
            ackR = 1'b1;
        end
        if (cReq && cWe && ackR) begin
            if (sel) mem32[cAddr[12:0]] = cWdata;
            else     mem16[cAddr[12:0]] = cWdata[15:0];
        end
    end

    accessT      expQ[$];
    logic [31:0] mAcc, mPc;
    logic        mCarry;
    int          mCycles;

    task automatic runModel(input logic [31:0] startPc);
        int          dw, aw, op;
        logic [63:0] dmask, amask, sum;
        logic [31:0] ir, a, m;
        logic        stop;
        accessT      e;
        dw = sel ? 32 : 16;
        aw = sel ? 20 : 13;
        dmask = (64'd1 << dw) - 64'd1;
        amask = (64'd1 << aw) - 64'd1;
        expQ.delete();
        mAcc = 0; mCarry = 0; mPc = startPc; mCycles = 0; stop = 0;
        for (int n = 0; n < 64 && !stop; n++) begin
            e.addr = mPc; e.we = 0; e.wdata = mAcc; e.fetch = 1; e.acc = mAcc; e.carry = mCarry;
            expQ.push_back(e);
            ir  = modelMem[mPc[12:0]];
            mPc = 32'((64'(mPc) + 64'd1) & amask);
            op  = int'((64'(ir) >> (dw - 3)) & 64'd7);
            a   = 32'(64'(ir) & amask);
            case (op)
                4: begin mPc = a; mCycles += 2; end
                5: begin if (mAcc == 0) mPc = a; mCycles += 2; end
                3: begin
                    e.addr = a; e.we = 1; e.wdata = mAcc; e.fetch = 0;
                    expQ.push_back(e);
                    modelMem[a[12:0]] = mAcc;
                    mCycles += 3;
                end
                7: begin mCycles += 2; stop = 1; end
                default: begin
                    m = modelMem[a[12:0]];
                    e.addr = a; e.we = 0; e.fetch = 0;
                    expQ.push_back(e);
                    mCycles += 4;
                    case (op)
                        0: begin sum = 64'(mAcc) + 64'(m); mCarry = sum[dw]; mAcc = 32'(sum & dmask); end
                        1: mAcc = mAcc & m;
                        2: mAcc = m;
                        default: begin mCarry = (mAcc < m); mAcc = 32'((64'(mAcc) - 64'(m)) & dmask); end
                    endcase
                end
            endcase
        end
    endtask

    // Compare process: every completed access against the model, every wait cycle for stability.
    logic        stab;
    logic [31:0] pAddr, pWdata;
    logic        pWe;
    always begin
        accessT e;
        @(negedge clk);
        #1;
        if (!cmpEn) begin
            stab = 1'b0;
        end else begin
            if (stab) begin
                check("stable_req", cReq, 1'b1);
                check("stable_addr", cAddr, pAddr);
                check("stable_we", cWe, pWe);
                check("stable_wdata", cWdata, pWdata);
            end
            stab = 1'b0;
            if (cReq && !cAck) begin
                stab = 1'b1; pAddr = cAddr; pWe = cWe; pWdata = cWdata;
            end else if (cReq && cAck) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_access: got access at 0x%0h, expected none", cAddr);
                end else begin
                    e = expQ.pop_front();
                    check("acc_addr", cAddr, e.addr);
                    check("acc_we", cWe, e.we);
                    if (e.we) check("acc_wdata", cWdata, e.wdata);
                    if (e.fetch) begin
                        check("fetch_pc", cPc, e.addr);
                        check("fetch_acc", cAcc, e.acc);
                        check("fetch_carry", cCarry, e.carry);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ins(input logic [2:0] op, input logic [19:0] a);
        if (sel) return {op, 9'b0, a};
        return {16'b0, op, a[12:0]};
    endfunction

    task automatic poke(input int a, input logic [31:0] d);
        modelMem[a] = d;
        if (sel) mem32[a] = d;
        else     mem16[a] = d[15:0];
    endtask

    task automatic clearMem();
        for (int i = 0; i < 8192; i++) begin
            mem16[i] = '0; mem32[i] = '0; modelMem[i] = '0;
        end
    endtask

    task automatic setRst(input logic v);
        if (sel) rst32 = v;
        else     rst16 = v;
    endtask

    task automatic enterReset();
        cmpEn = 1'b0;
        @(negedge clk);
        #2;
        setRst(1'b0);
        repeat (2) @(posedge clk);
    endtask

    task automatic loadProgA(input int base);
        poke(base + 0, ins(OP_LDA, 20'(base + 10)));
        poke(base + 1, ins(OP_ADD, 20'(base + 11)));
        poke(base + 2, ins(OP_STA, 20'(base + 12)));
        poke(base + 3, ins(OP_HALT, 20'd0));
        poke(base + 10, 32'd5);
        poke(base + 11, 32'd7);
    endtask

    task automatic runProgram(input logic [31:0] startPc, output int cycles);
        logic done;
        @(posedge clk);
        #2;
        cmpEn = 1'b1;
        setRst(1'b1);
        #1;
        check("first_req", cReq, 1'b1);
        check("first_addr", cAddr, startPc);
        cycles = 0;
        done = 0;
        while (!done && cycles < 1000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            #2;
            if (cHalted) done = 1;
        end
        check("halt_reached", done, 1'b1);
        check("model_queue_drained", expQ.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int waited;
        sel = 0; mode = 0; spurious = 0; holdAddr = -1; ackR = 0;
        pending = 0; remaining = 0; cmpEn = 0; stab = 0;
        rst16 = 1; rst32 = 1;
        clearMem();
        #1;
        rst16 = 0; rst32 = 0;
        #3;
        check("rst_req16", bus16.mem_req, 1'b0);
        check("rst_we16", bus16.mem_we, 1'b0);
        check("rst_halted16", halted16, 1'b0);
        check("rst_pc16", pc16, 13'h0);
        check("rst_acc16", acc16, 16'h0);
        check("rst_carry16", carry16, 1'b0);
        check("rst_req32", bus32.mem_req, 1'b0);
        check("rst_pc32", pc32, 20'h100);

        // Zero-wait program
        loadProgA(0);
        runModel(32'h0);
        check("model_a_acc", mAcc, 32'd12);
        check("model_a_mem12", modelMem[12], 32'd12);
        check("model_a_cycles", mCycles, 13);
        runProgram(32'h0, cyc);
        check("a_cycles", cyc, 13);
        check("a_cycles_model", cyc, mCycles);
        check("a_mem12", mem16[12], 16'd12);
        check("a_acc", acc16, 16'd12);
        check("a_carry", carry16, 1'b0);
        check("a_halted", halted16, 1'b1);
        repeat (5) @(negedge clk);
        #2;
        check("a_halt_hold", halted16, 1'b1);
        check("a_halt_pc", pc16, 13'd4);
        check("a_halt_noreq", bus16.mem_req, 1'b0);

        // Carry and borrow
        enterReset();
        clearMem();
        poke(0, ins(OP_LDA, 20'd30));
        poke(1, ins(OP_ADD, 20'd31));
        poke(2, ins(OP_SUB, 20'd31));
        poke(3, ins(OP_AND, 20'd32));
        poke(4, ins(OP_HALT, 20'd0));
        poke(30, 32'hFFFF);
        poke(31, 32'h1);
        poke(32, 32'h00F0);
        runModel(32'h0);
        check("model_after_add_acc", expQ[4].acc, 32'h0);
        check("model_after_add_carry", expQ[4].carry, 1'b1);
        check("model_after_sub_acc", expQ[6].acc, 32'hFFFF);
        check("model_after_sub_carry", expQ[6].carry, 1'b1);
        check("model_c_acc", mAcc, 32'h00F0);
        runProgram(32'h0, cyc);
        check("c_acc", acc16, 16'h00F0);
        check("c_carry", carry16, 1'b1);

        // Branches and PC wrap
        enterReset();
        clearMem();
        poke(0, ins(OP_JZ, 20'd20));
        poke(1, ins(OP_HALT, 20'd0));
        poke(20, ins(OP_LDA, 20'd40));
        poke(21, ins(OP_JZ, 20'd50));
        poke(22, ins(OP_JMP, 20'h1FFF));
        poke(8191, ins(OP_LDA, 20'd42));
        poke(40, 32'd3);
        poke(42, 32'd9);
        runModel(32'h0);
        check("model_jz_taken", expQ[1].addr, 32'd20);
        check("model_jz_not_taken", expQ[4].addr, 32'd22);
        check("model_jmp_target", expQ[5].addr, 32'h1FFF);
        check("model_pc_wrap", expQ[7].addr, 32'd0);
        runProgram(32'h0, cyc);
        check("b_cycles_model", cyc, mCycles);
        check("b_pc", pc16, 13'd2);
        check("b_acc", acc16, 16'd9);

        // Random wait states with spurious acks while idle
        enterReset();
        clearMem();
        mode = 1; spurious = 1;
        loadProgA(0);
        runModel(32'h0);
        runProgram(32'h0, cyc);
        check("w_mem12", mem16[12], 16'd12);
        check("w_acc", acc16, 16'd12);
        check("w_carry", carry16, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        check("w_halt_hold", halted16, 1'b1);
        check("w_halt_pc", pc16, 13'd4);
        check("w_halt_acc", acc16, 16'd12);

        // Reset while READ waits for its ack
        enterReset();
        clearMem();
        mode = 2; spurious = 0; holdAddr = 11;
        loadProgA(0);
        runModel(32'h0);
        @(posedge clk);
        #2;
        cmpEn = 1;
        rst16 = 1;
        waited = 0;
        while (!(cReq && cAddr == 11) && waited < 100) begin
            @(negedge clk);
            #2;
            waited++;
        end
        check("r_read_addr", cAddr, 32'd11);
        repeat (3) @(negedge clk);
        #2;
        check("r_still_waiting", cReq, 1'b1);
        check("r_acc_before", acc16, 16'd5);
        cmpEn = 0;
        rst16 = 0;
        #1;
        check("r_req_drop", bus16.mem_req, 1'b0);
        check("r_pc", pc16, 13'h0);
        check("r_acc", acc16, 16'h0);
        check("r_halted", halted16, 1'b0);
        mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("r_late_ack_acc", acc16, 16'h0);
        check("r_late_ack_pc", pc16, 13'h0);
        check("r_late_ack_mem12", mem16[12], 16'd0);
        runModel(32'h0);
        runProgram(32'h0, cyc);
        check("r_rerun_cycles", cyc, 13);
        check("r_rerun_mem12", mem16[12], 16'd12);

        // Wide configuration relocated to 0x100
        enterReset();
        sel = 1;
        mode = 0;
        #1;
        clearMem();
        loadProgA(32'h100);
        runModel(32'h100);
        check("model_32_acc", mAcc, 32'd12);
        runProgram(32'h100, cyc);
        check("w32_cycles", cyc, 13);
        check("w32_mem", mem32[13'h10C], 32'd12);
        check("w32_acc", acc32, 32'd12);
        check("w32_carry", carry32, 1'b0);
        check("w32_halted", halted32, 1'b1);
        check("w32_pc", pc32, 20'h104);
        cmpEn = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
